// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared register-file sizing constants for the scoreboarded register file
package arm_pkg;

  localparam int REG_IDX_W  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = REG_IDX_W;
  localparam int DEF_N_RD   = 3;

  // True when an enabled write port targets the given register index.
  function automatic logic wr_hits(input logic en, input logic [REG_IDX_W-1:0] waddr,
                                   input logic [REG_IDX_W-1:0] raddr);
    return en && (waddr == raddr);
  endfunction

endpackage

// File: rtl/sb_scoreboard.sv
// rtl/sb_scoreboard.sv - one busy bit per register: set by issue, cleared by writeback
module sb_scoreboard
  import arm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   wr0_en,
  input  logic [ADDR_W-1:0]      wr0_addr,
  input  logic                   wr1_en,
  input  logic [ADDR_W-1:0]      wr1_addr,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Issue is applied last so a new producer outranks a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[wr0_addr] = 1'b0;
    if (wr1_en) busy_d[wr1_addr] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/sb_reg_file.sv
// rtl/sb_reg_file.sv - multi-read, dual-write register file with write-through bypass and busy scoreboard
module sb_reg_file
  import arm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = DEF_N_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     stall
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Port 1 is applied after port 0 so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr0_en) regs_d[wr0_addr] = wr0_data;
    if (wr1_en) regs_d[wr1_addr] = wr1_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  sb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;

    assign ra   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit0 = wr0_en && (wr0_addr == ra);
    assign hit1 = wr1_en && (wr1_addr == ra);

    // A bypassed value is already available, so it never reports busy.
    assign rd_data[k*DATA_W +: DATA_W] = hit1 ? wr1_data : (hit0 ? wr0_data : regs_q[ra]);
    assign rd_busy[k] = busy[ra] & ~(hit0 | hit1);
  end

  assign stall = |rd_busy;

endmodule

// File: tb/tb_sb_reg_file.sv
// tb/tb_sb_reg_file.sv - self-checking bench for sb_reg_file against a behavioural register/busy model
module tb_sb_reg_file;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int NREG = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en, wr1_en, iss_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic              stall;

  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;

  logic [DW-1:0] m_regs [NREG];
  bit            m_busy [NREG];

  sb_reg_file #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  // Architectural model: reset clears everything; writes land (wr1 last), busy cleared by writes, set by issue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr0_en) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
      if (wr1_en) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
      if (iss_en) m_busy[iss_addr] = 1'b1;
    end
  end

  // Per-cycle comparison of every read port plus stall against the model.
  always @(negedge clk) begin
    if (!done) begin
      bit any_busy;
      any_busy = 1'b0;
      for (int k = 0; k < NR; k++) begin
        int a;
        logic [DW-1:0] ed;
        bit eb;
        a = int'(rd_addr[k*AW +: AW]);
        if (wr1_en && int'(wr1_addr) == a)      begin ed = wr1_data; eb = 1'b0; end
        else if (wr0_en && int'(wr0_addr) == a) begin ed = wr0_data; eb = 1'b0; end
        else                                    begin ed = m_regs[a]; eb = m_busy[a]; end
        chk($sformatf("cyc_rd_data[%0d]", k), rd_data[k*DW +: DW], ed);
        chk($sformatf("cyc_rd_busy[%0d]", k), {31'b0, rd_busy[k]}, {31'b0, eb});
        any_busy |= eb;
      end
      chk("cyc_stall", {31'b0, stall}, {31'b0, any_busy});
    end
  end

  task automatic idle();
    wr0_en = 0; wr1_en = 0; iss_en = 0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dat(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    set_rd(0, 0, 0);
    #12;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_rd_busy", {29'b0, rd_busy}, 32'd0);
    rst = 1'b0;
    tick();

    // All registers read zero on three ports after reset.
    for (int i = 0; i < NREG; i++) begin
      set_rd(i, (i + 5) % NREG, (i + 10) % NREG);
      #1;
      for (int k = 0; k < NR; k++) chk($sformatf("post_reset_r%0d_p%0d", i, k), dat(k), 32'd0);
      chk("post_reset_stall", {31'b0, stall}, 32'd0);
      tick();
    end

    // Same-address dual write: port 1 wins, both in bypass and in storage.
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h1111_1111;
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h2222_2222;
    set_rd(3, 0, 0);
    #1 chk("dual_wr_bypass_r3", dat(0), 32'h2222_2222);
    tick();
    idle();
    #1 chk("dual_wr_stored_r3", dat(0), 32'h2222_2222);
    tick();

    // Write-through bypass then stored value.
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
    set_rd(0, 5, 0);
    #1 chk("bypass_r5", dat(1), 32'hDEAD_BEEF);
    tick();
    idle();
    #1 chk("stored_r5", dat(1), 32'hDEAD_BEEF);
    tick();

    // Issue R7, observe busy, clear it with a bypassed writeback.
    iss_en = 1; iss_addr = 7;
    set_rd(0, 0, 7);
    #1 chk("iss_r7_not_yet_busy", {29'b0, rd_busy}, 32'd0);
    tick();
    idle();
    #1 chk("r7_busy", {29'b0, rd_busy}, 32'b100);
    chk("r7_stall", {31'b0, stall}, 32'd1);
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h5;
    #1 chk("r7_bypass_busy", {29'b0, rd_busy}, 32'd0);
    chk("r7_bypass_data", dat(2), 32'h5);
    chk("r7_bypass_stall", {31'b0, stall}, 32'd0);
    tick();
    idle();
    #1 chk("r7_after_wr_busy", {29'b0, rd_busy}, 32'd0);
    chk("r7_after_wr_data", dat(2), 32'h5);
    tick();

    // Issue and write to R2 in the same cycle: data lands, busy stays set.
    iss_en = 1; iss_addr = 2;
    wr1_en = 1; wr1_addr = 2; wr1_data = 32'h9;
    set_rd(2, 0, 0);
    tick();
    idle();
    #1 chk("r2_data", dat(0), 32'h9);
    chk("r2_busy", {29'b0, rd_busy}, 32'b001);
    wr1_en = 1; wr1_addr = 2; wr1_data = 32'hAB;
    tick();
    idle();
    #1 chk("r2_cleared", {29'b0, rd_busy}, 32'd0);
    tick();

    // Write to a non-busy register; double issue then a single write clears.
    wr0_en = 1; wr0_addr = 8; wr0_data = 32'h0808_0808;
    set_rd(8, 9, 0);
    tick();
    idle();
    iss_en = 1; iss_addr = 9;
    #1 chk("r8_not_busy", {29'b0, rd_busy}, 32'd0);
    tick();
    tick();
    idle();
    #1 chk("r9_double_iss_busy", {29'b0, rd_busy}, 32'b010);
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99;
    tick();
    idle();
    #1 chk("r9_single_clear", {29'b0, rd_busy}, 32'd0);
    chk("r9_data", dat(1), 32'h99);
    tick();

    // Varied directed traffic for the per-cycle comparator.
    for (int i = 0; i < 24; i++) begin
      wr0_en = (i % 3) != 0; wr0_addr = AW'(i * 5);     wr0_data = 32'h1000_0000 + i;
      wr1_en = (i % 4) == 1; wr1_addr = AW'(i * 7);     wr1_data = 32'h2000_0000 + i;
      iss_en = (i % 2) == 0; iss_addr = AW'(i * 3 + 1);
      set_rd((i * 3 + 1) % NREG, (i * 5) % NREG, (i * 11 + 2) % NREG);
      tick();
    end
    idle();
    tick();

    // Asynchronous reset mid-cycle clears data and busy at once.
    wr0_en = 1; wr0_addr = 1; wr0_data = 32'hFF;
    iss_en = 1; iss_addr = 4;
    tick();
    idle();
    set_rd(1, 4, 0);
    #1 chk("pre_rst_r1", dat(0), 32'hFF);
    chk("pre_rst_r4_busy", {29'b0, rd_busy}, 32'b010);
    #1 rst = 1'b1;
    #1 chk("async_rst_r1", dat(0), 32'd0);
    chk("async_rst_busy", {29'b0, rd_busy}, 32'd0);
    chk("async_rst_stall", {31'b0, stall}, 32'd0);
    // Activity across an edge while reset is held must be ignored.
    wr0_en = 1; wr0_addr = 6; wr0_data = 32'h77;
    iss_en = 1; iss_addr = 6;
    set_rd(0, 0, 6);
    tick();
    idle();
    #1 chk("rst_ignored_r6_data", dat(2), 32'd0);
    chk("rst_ignored_r6_busy", {29'b0, rd_busy}, 32'd0);
    #1 rst = 1'b0;
    tick();
    #1 chk("after_rst_r6", dat(2), 32'd0);
    chk("after_rst_stall", {31'b0, stall}, 32'd0);
    tick();

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sb_reg_file.md
SB_REG_FILE -- requirements
Module: sb_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register index width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter N_RD, default 3, number of independent read ports.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rd_addr  input  N_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rd_data  output  N_RD*DATA_W  read values, port k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port rd_busy  output  N_RD  port k source has an outstanding producer.
REQ-009 SHALL have ports wr0_en/wr0_addr/wr0_data  input  1/ADDR_W/DATA_W  write port 0 (ALU writeback).
REQ-010 SHALL have ports wr1_en/wr1_addr/wr1_data  input  1/ADDR_W/DATA_W  write port 1 (load/base writeback).
REQ-011 SHALL have ports iss_en/iss_addr  input  1/ADDR_W  instruction issue claiming a destination register.
REQ-012 SHALL have port stall  output  1  OR of rd_busy over all ports.

Function
REQ-013 SHALL store DEPTH registers of DATA_W bits; writes commit on rising clk edge when enabled.
REQ-014 SHALL give port 1 priority when wr0_en and wr1_en target the same address in one cycle; port 0 value is discarded.
REQ-015 SHALL read combinationally with write-through bypass: rd_data equals the same-cycle write value when the index matches an enabled write (port 1 over port 0), else stored value.
REQ-016 SHALL keep one busy bit per register: set at edge when iss_en targets it; cleared at edge when any enabled write targets it.
REQ-017 SHALL, when issue and write target the same register in one cycle, leave busy set (new producer wins).
REQ-018 SHALL drive rd_busy[k] = busy[idx] AND NOT (enabled write to idx this cycle), i.e. bypassed values are not busy.
REQ-019 SHALL allow a write to a non-busy register (no error, busy stays clear).
REQ-020 SHALL allow re-issue to an already busy register (busy stays set; single bit, no counting).
REQ-021 SHALL have zero-cycle read latency and one-cycle write/issue-to-visible-state latency.

Reset
REQ-022 SHALL on rst clear all registers to 0 and all busy bits to 0 immediately, independent of clk.
REQ-023 SHALL ignore writes and issues while rst is high; reset overrides any same-edge activity.
REQ-024 SHALL output rd_data = 0 (barring bypass), rd_busy = 0, stall = 0 during and after reset.

Structure
REQ-025 SHALL take DATA_W/ADDR_W/N_RD defaults and the register-index width constant from shared package arm_pkg.
REQ-026 SHALL implement busy tracking in one sub-module sb_scoreboard (busy vector, set/clear logic); storage and bypass stay in sb_reg_file.
REQ-027 SHALL be synthesizable for any N_RD >= 1 and ADDR_W >= 1 using generate loops for read ports.

Verification
REQ-028 Reset then read all 16 registers on 3 ports -> all rd_data 0, stall 0.
REQ-029 wr0 R3=0x11111111 and wr1 R3=0x22222222 same cycle; read R3 next cycle -> 0x22222222.
REQ-030 wr0 R5=0xDEADBEEF, same cycle read R5 -> 0xDEADBEEF combinationally; stored value also 0xDEADBEEF after edge.
REQ-031 iss R7; next cycle read R7 -> rd_busy=1, stall=1; wr0 R7=0x5 -> same cycle rd_busy=0, rd_data=0x5; next cycle busy 0.
REQ-032 iss R2 and wr1 R2=0x9 same cycle -> after edge R2=0x9 and busy set.
REQ-033 Write R1=0xFF, iss R4, assert rst mid-cycle -> immediate R1=0, busy clear, stall 0.
